// File: rtl/register_bus_reader_pkg.sv
// Shared definitions for the register bus reader.
//   state_e    : controller states (IDLE/SELECT/CAPTURE/HOLD)
//   CNT_W      : settle counter width (settle time 1..15 Tick cycles)
//   cs_n_bit() : one-hot-low chip-select helper, one bit at a time, so any
//                register count and address width can use it
package register_bus_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_CAPTURE,
    ST_HOLD
  } state_e;

  localparam int CNT_W = 4;

  // Low only for the addressed position while enabled; an index that matches
  // no position leaves every bit high.
  function automatic logic cs_n_bit(input int unsigned idx,
                                    input int unsigned pos,
                                    input logic        en);
    return !(en && (idx == pos));
  endfunction

endpackage

// File: rtl/register_bus_reader_cs_dec.sv
// Chip-select decoder: turns a registered register index plus enable into a
// one-hot-low select vector. All ones when disabled or index out of range.
//   idx_i  : register index (driven from a register)
//   en_i   : select enable (driven from a register)
//   cs_n_o : per-register chip-select, 1 = register tri-stated
module register_bus_reader_cs_dec
  import register_bus_reader_pkg::*;
#(
  parameter int NrOfRegs = 4,
  parameter int AddrBits = 2
) (
  input  logic [AddrBits-1:0] idx_i,
  input  logic                en_i,
  output logic [NrOfRegs-1:0] cs_n_o
);

  always_comb begin
    for (int i = 0; i < NrOfRegs; i++) begin
      cs_n_o[i] = cs_n_bit(32'(idx_i), 32'(i), en_i);
    end
  end

endmodule

// File: rtl/register_bus_reader.sv
// Read-side controller for a bank of tri-state registers sharing one bus.
// Accepts single/burst read requests, selects one register at a time
// (break-before-make), waits a settle time, samples the bus and returns each
// word over a valid/ready handshake.
//   Clock, Reset      : clock, synchronous active-high reset
//   Tick              : global enable for acceptance and settle/capture
//   req_*             : request handshake, first index and word count
//   cs_n              : per-register chip-selects (1 = tri-stated)
//   bus_in            : shared register bus
//   rd_*              : returned word, its index, error and last flags
//   busy              : controller not idle
module register_bus_reader
  import register_bus_reader_pkg::*;
#(
  parameter int NrOfBits     = 8,
  parameter int NrOfRegs     = 4,
  parameter int AddrBits     = 2,
  parameter int SettleCycles = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [AddrBits-1:0] req_addr,
  input  logic [AddrBits:0]   req_len,
  output logic [NrOfRegs-1:0] cs_n,
  input  logic [NrOfBits-1:0] bus_in,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [NrOfBits-1:0] rd_data,
  output logic [AddrBits-1:0] rd_addr,
  output logic                rd_err,
  output logic                rd_last,
  output logic                busy
);

  localparam logic [AddrBits:0] ONE_W  = (AddrBits + 1)'(1);
  localparam logic [AddrBits:0] NREGS  = (AddrBits + 1)'(NrOfRegs);
  localparam logic [CNT_W-1:0]  SETTLE = CNT_W'(SettleCycles);

  state_e              state_q;
  logic [AddrBits-1:0] cur_addr_q;
  logic [AddrBits:0]   remain_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                cs_en_q;
  logic [NrOfBits-1:0] rd_data_q;
  logic [AddrBits-1:0] rd_addr_q;
  logic                rd_err_q;
  logic                rd_last_q;

  logic [AddrBits:0]   addr_inc_d;
  logic [AddrBits-1:0] addr_nxt_d;
  logic [AddrBits:0]   len_eff_d;
  logic [AddrBits:0]   rem_dec_d;

  function automatic logic in_range(input logic [AddrBits-1:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  always_comb begin
    addr_inc_d = {1'b0, cur_addr_q} + ONE_W;
    // Wrap at the register count; an out-of-range index wraps by truncation.
    addr_nxt_d = (addr_inc_d == NREGS) ? '0 : addr_inc_d[AddrBits-1:0];
    len_eff_d  = (req_len == '0) ? ONE_W : req_len;
    rem_dec_d  = remain_q - ONE_W;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      cnt_q      <= '0;
      cs_en_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_err_q   <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid && Tick) begin
            cur_addr_q <= req_addr;
            remain_q   <= len_eff_d;
            cnt_q      <= SETTLE;
            if (in_range(req_addr)) begin
              state_q <= ST_SELECT;
              cs_en_q <= 1'b1;
            end else begin
              // No register answers this index: report an error word
              // without ever driving a select.
              state_q   <= ST_HOLD;
              rd_err_q  <= 1'b1;
              rd_data_q <= '0;
              rd_addr_q <= req_addr;
              rd_last_q <= (len_eff_d == ONE_W);
            end
          end
        end
        ST_SELECT: begin
          if (Tick) begin
            if (cnt_q == CNT_W'(1)) state_q <= ST_CAPTURE;
            else                    cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (Tick) begin
            rd_data_q <= bus_in;
            rd_addr_q <= cur_addr_q;
            rd_err_q  <= 1'b0;
            rd_last_q <= (remain_q == ONE_W);
            cs_en_q   <= 1'b0;
            state_q   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Consumer handshake is not Tick-gated.
          if (rd_ready) begin
            remain_q <= rem_dec_d;
            if (rem_dec_d == '0) begin
              state_q <= ST_IDLE;
            end else begin
              cur_addr_q <= addr_nxt_d;
              cnt_q      <= SETTLE;
              if (in_range(addr_nxt_d)) begin
                state_q <= ST_SELECT;
                cs_en_q <= 1'b1;
              end else begin
                state_q   <= ST_HOLD;
                rd_err_q  <= 1'b1;
                rd_data_q <= '0;
                rd_addr_q <= addr_nxt_d;
                rd_last_q <= (rem_dec_d == ONE_W);
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  register_bus_reader_cs_dec #(
    .NrOfRegs(NrOfRegs),
    .AddrBits(AddrBits)
  ) u_cs_dec (
    .idx_i (cur_addr_q),
    .en_i  (cs_en_q),
    .cs_n_o(cs_n)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rd_valid  = (state_q == ST_HOLD);
  assign rd_data   = rd_data_q;
  assign rd_addr   = rd_addr_q;
  assign rd_err    = rd_err_q;
  assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_register_bus_reader.sv
module tb_register_bus_reader;

  logic Clock;
  logic Reset;
  logic Tick;

  logic       req_valid [2];
  logic       rd_ready  [2];
  logic [1:0] req_addr  [2];
  logic [2:0] req_len   [2];
  logic       req_ready [2];
  logic       rd_valid  [2];
  logic       rd_err    [2];
  logic       rd_last   [2];
  logic       busy      [2];
  logic [7:0] rd_data   [2];
  logic [1:0] rd_addr   [2];
  logic [3:0] csn       [2];

  logic [7:0] regs [4];
  logic [7:0] junk;

  int nregs  [2] = '{4, 3};
  int settle [2] = '{1, 3};
  int tick_mode;
  int ecnt;
  int nerr;
  int nchk;

  function automatic logic [3:0] onehot_n(input int i);
    logic [3:0] r;
    r = 4'hF;
    r[2'(i)] = 1'b0;
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_unit
    localparam int NR = (g == 0) ? 4 : 3;
    localparam int SC = (g == 0) ? 1 : 3;
    logic [NR-1:0] cs_loc;
    logic [3:0]    cs_w;
    logic [7:0]    bus_loc;

    always_comb begin
      cs_w = 4'hF;
      cs_w[NR-1:0] = cs_loc;
    end

    // Bus model: the single selected register drives, otherwise floating junk.
    always_comb begin
      bus_loc = junk;
      for (int i = 0; i < 4; i++) if (cs_w == onehot_n(i)) bus_loc = regs[i];
    end

    assign csn[g] = cs_w;

    register_bus_reader #(
      .NrOfBits(8), .NrOfRegs(NR), .AddrBits(2), .SettleCycles(SC)
    ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Tick     (Tick),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr[g]),
      .req_len  (req_len[g]),
      .cs_n     (cs_loc),
      .bus_in   (bus_loc),
      .rd_valid (rd_valid[g]),
      .rd_ready (rd_ready[g]),
      .rd_data  (rd_data[g]),
      .rd_addr  (rd_addr[g]),
      .rd_err   (rd_err[g]),
      .rd_last  (rd_last[g]),
      .busy     (busy[g])
    );
  end

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    Tick = (tick_mode == 0) ? 1'b1 : ((ecnt % 3) == 0);
    @(posedge Clock);
    #1;
    ecnt++;
    junk = 8'($urandom);
  endtask

  // Bus invariants on both units every cycle.
  logic [3:0] prev_cs [2];
  always @(negedge Clock) begin
    for (int u = 0; u < 2; u++) begin
      chk("one_cs_low", 32'($countones(~csn[u]) <= 1), 1);
      if (prev_cs[u] !== 4'hF && prev_cs[u] !== 4'hx && csn[u] !== 4'hF)
        chk("cs_break_before_make", csn[u], prev_cs[u]);
      prev_cs[u] = csn[u];
    end
  end

  task automatic check_reset(input int u);
    chk("rst_cs_n", csn[u], 4'hF);
    chk("rst_rd_valid", rd_valid[u], 0);
    chk("rst_rd_err", rd_err[u], 0);
    chk("rst_rd_last", rd_last[u], 0);
    chk("rst_busy", busy[u], 0);
    chk("rst_req_ready", req_ready[u], 1);
    chk("rst_rd_data", rd_data[u], 0);
    chk("rst_rd_addr", rd_addr[u], 0);
  endtask

  task automatic check_word(input int u, input int a, input logic [7:0] ed,
                            input bit err, input bit last);
    chk("rd_valid", rd_valid[u], 1);
    chk("rd_data", rd_data[u], ed);
    chk("rd_addr", rd_addr[u], a);
    chk("rd_err", rd_err[u], err);
    chk("rd_last", rd_last[u], last);
    chk("hold_cs_n", csn[u], 4'hF);
    chk("hold_req_ready", req_ready[u], 0);
    chk("hold_busy", busy[u], 1);
  endtask

  task automatic start_req(input int u, input int addr, input int len);
    int  steps;
    bit  acc;
    steps = 0;
    acc   = 0;
    req_valid[u] = 1'b1;
    req_addr[u]  = 2'(addr);
    req_len[u]   = 3'(len);
    while (!acc && steps < 50) begin
      chk("req_ready_idle", req_ready[u], 1);
      step();
      steps++;
      chk("accept_on_tick", busy[u], Tick);
      acc = busy[u];
    end
    req_valid[u] = 1'b0;
    if (!acc) chk("accept_timeout", busy[u], 1);
  endtask

  task automatic run_req(input int u, input int addr, input int len, input int stall);
    int         n, a, steps, tks;
    bit         err, last_t;
    logic [7:0] ed;
    n = (len == 0) ? 1 : len;
    start_req(u, addr, len);
    a = addr;
    for (int k = 0; k < n; k++) begin
      err    = (a >= nregs[u]);
      ed     = err ? 8'h00 : regs[a];
      steps  = 0;
      tks    = 0;
      last_t = 1'b1;
      while (!rd_valid[u] && steps < 400) begin
        chk("cs_select", csn[u], onehot_n(a));
        step();
        steps++;
        if (Tick) tks++;
        last_t = Tick;
      end
      if (!rd_valid[u]) begin
        chk("rd_valid_timeout", rd_valid[u], 1);
        return;
      end
      chk("settle_ticks", tks, err ? 0 : settle[u] + 1);
      chk("capture_on_tick", last_t, 1);
      check_word(u, a, ed, err, k == n - 1);
      for (int s = 0; s < stall; s++) begin
        step();
        check_word(u, a, ed, err, k == n - 1);
      end
      rd_ready[u] = 1'b1;
      step();
      rd_ready[u] = 1'b0;
      if (k == n - 1) begin
        chk("done_busy", busy[u], 0);
        chk("done_req_ready", req_ready[u], 1);
        chk("done_rd_valid", rd_valid[u], 0);
        chk("done_cs_n", csn[u], 4'hF);
      end
      a = ((a + 1) == nregs[u]) ? 0 : ((a + 1) % 4);
    end
  endtask

  initial begin
    int s;
    nerr = 0;
    nchk = 0;
    ecnt = 0;
    tick_mode = 0;
    Reset = 1'b1;
    Tick  = 1'b0;
    junk  = 8'h5C;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      rd_ready[u]  = 1'b0;
      req_addr[u]  = 2'd0;
      req_len[u]   = 3'd0;
    end
    for (int r = 0; r < 4; r++) regs[r] = 8'h00;
    repeat (3) step();
    check_reset(0);
    check_reset(1);
    Reset = 1'b0;
    step();

    // Single read of register 2.
    regs[0] = 8'h01; regs[1] = 8'h02; regs[2] = 8'hA5; regs[3] = 8'h04;
    run_req(0, 2, 1, 0);

    // Burst wrapping past the last register.
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
    run_req(0, 3, 3, 0);

    // Consumer stalls five cycles per word; length 0 reads one word.
    run_req(0, 1, 2, 5);
    run_req(0, 0, 0, 1);

    // Three-register bank: index 3 is an error, index 0 succeeds after it.
    run_req(1, 3, 1, 0);
    run_req(1, 0, 1, 0);
    run_req(1, 2, 3, 1);

    // Reset while selecting.
    start_req(0, 1, 2);
    chk("in_select", csn[0], onehot_n(1));
    Reset = 1'b1;
    step();
    check_reset(0);
    Reset = 1'b0;
    repeat (8) begin
      step();
      chk("no_stale_valid", rd_valid[0], 0);
      chk("no_stale_cs", csn[0], 4'hF);
    end

    // Reset while holding a word.
    start_req(0, 2, 1);
    s = 0;
    while (!rd_valid[0] && s < 50) begin
      step();
      s++;
    end
    chk("hold_reached", rd_valid[0], 1);
    Reset = 1'b1;
    step();
    check_reset(0);
    Reset = 1'b0;
    repeat (8) begin
      step();
      chk("no_stale_valid", rd_valid[0], 0);
    end
    run_req(0, 0, 2, 0);

    // Tick on every third cycle only.
    tick_mode = 1;
    step();
    run_req(0, 2, 1, 1);
    run_req(0, 3, 3, 2);
    run_req(1, 2, 2, 0);

    // Randomized requests, both units, both Tick patterns.
    for (int i = 0; i < 40; i++) begin
      tick_mode = $urandom_range(0, 1);
      for (int r = 0; r < 4; r++) regs[r] = 8'($urandom);
      run_req($urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 7), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
